// File: rtl/desc_sched.sv
// ---------------------------------------------------------------------------
// desc_sched
//   Per-queue descriptor credit counters feeding a round-robin grant
//   scheduler. Credits add to a queue's count and each accepted grant
//   consumes one descriptor. A queue clear zeroes the count and withdraws
//   an outstanding grant to that queue.
//
//   Optional feature: define DESC_SCHED_SAT_EN to clamp the counters at
//   2^DESC_CNT_WIDTH-1. Without it the counters wrap.
//
// Ports
//   user_clk      in   clock, rising edge
//   user_reset_n  in   asynchronous active-low reset
//   cred_vld      in   credit update strobe
//   cred_qid      in   queue receiving credits
//   cred_val      in   number of descriptors added
//   clr_vld       in   queue clear strobe
//   clr_qid       in   queue to clear
//   gnt_vld       out  grant offered (registered)
//   gnt_qid       out  granted queue (registered)
//   gnt_rdy       in   consumer accepts grant
//   q_cnt         out  packed counters, queue 0 in LSBs
//   q_rdy         out  per-queue non-zero flag
// ---------------------------------------------------------------------------
module desc_sched #(
    parameter int NUM_Q            = 4,
    parameter int QID_WIDTH        = 2,
    parameter int DESC_CNT_WIDTH   = 16,
    parameter int DESC_AVAIL_WIDTH = 8
) (
    input  logic                              user_clk,
    input  logic                              user_reset_n,
    input  logic                              cred_vld,
    input  logic [QID_WIDTH-1:0]              cred_qid,
    input  logic [DESC_AVAIL_WIDTH-1:0]       cred_val,
    input  logic                              clr_vld,
    input  logic [QID_WIDTH-1:0]              clr_qid,
    output logic                              gnt_vld,
    output logic [QID_WIDTH-1:0]              gnt_qid,
    input  logic                              gnt_rdy,
    output logic [NUM_Q*DESC_CNT_WIDTH-1:0]   q_cnt,
    output logic [NUM_Q-1:0]                  q_rdy
);

    localparam int unsigned NQ = NUM_Q;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [DESC_CNT_WIDTH-1:0]   cnt     [NUM_Q];
    logic [DESC_CNT_WIDTH-1:0]   cnt_nxt [NUM_Q];
    logic [QID_WIDTH-1:0]        last_qid;
    logic [QID_WIDTH-1:0]        last_qid_nxt;
    logic [QID_WIDTH-1:0]        gnt_qid_nxt;
    logic                        gnt_vld_nxt;
    logic [NUM_Q-1:0]            clr_hit;
    logic [NUM_Q-1:0]            inc_hit;
    logic [NUM_Q-1:0]            dec_hit;
    logic [NUM_Q-1:0]            elig;
    logic                        withdraw;
    logic                        accept;
    logic                        sel_found;
    logic [QID_WIDTH-1:0]        sel_qid;

`ifdef DESC_SCHED_SAT_EN
    localparam int SW = DESC_CNT_WIDTH + 1;
    logic [DESC_CNT_WIDTH:0]     sum [NUM_Q];
`else
    localparam int SW = DESC_CNT_WIDTH;
    logic [DESC_CNT_WIDTH-1:0]   sum [NUM_Q];
`endif

    // A clear of the granted queue beats a same-cycle accept.
    assign withdraw = (state == GRANT) && clr_vld && (clr_qid == gnt_qid);
    assign accept   = (state == GRANT) && gnt_vld && gnt_rdy && !withdraw;

    always_comb begin
        for (int unsigned i = 0; i < NQ; i++) begin
            clr_hit[i] = clr_vld  && (clr_qid  == QID_WIDTH'(i));
            inc_hit[i] = cred_vld && (cred_qid == QID_WIDTH'(i));
            dec_hit[i] = accept && (gnt_qid == QID_WIDTH'(i)) && (cnt[i] != '0);
            elig[i]    = (cnt[i] != '0) && !clr_hit[i];
        end
    end

    // Counter arithmetic; inc and dec together give count + val - 1.
    always_comb begin
        for (int unsigned i = 0; i < NQ; i++) begin
            sum[i] = SW'(cnt[i])
                   + (inc_hit[i] ? SW'(cred_val) : '0)
                   - (dec_hit[i] ? SW'(1)        : '0);
`ifdef DESC_SCHED_SAT_EN
            cnt_nxt[i] = sum[i][DESC_CNT_WIDTH] ? '1 : sum[i][DESC_CNT_WIDTH-1:0];
`else
            cnt_nxt[i] = sum[i];
`endif
            if (clr_hit[i]) begin
                cnt_nxt[i] = '0;
            end
        end
    end

    // Round-robin pick: first eligible queue strictly after last_qid.
    always_comb begin
        sel_found = 1'b0;
        sel_qid   = '0;
        for (int unsigned k = 1; k <= NQ; k++) begin
            int unsigned idx;
            idx = (int'(last_qid) + k) % NQ;
            if (!sel_found && elig[QID_WIDTH'(idx)]) begin
                sel_found = 1'b1;
                sel_qid   = QID_WIDTH'(idx);
            end
        end
    end

    // State register, registered grant outputs and counters.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state    <= IDLE;
            gnt_vld  <= 1'b0;
            gnt_qid  <= '0;
            last_qid <= QID_WIDTH'(NUM_Q - 1);
            for (int unsigned i = 0; i < NQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            gnt_vld  <= gnt_vld_nxt;
            gnt_qid  <= gnt_qid_nxt;
            last_qid <= last_qid_nxt;
            for (int unsigned i = 0; i < NQ; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = sel_found ? GRANT : IDLE;
            GRANT:   state_nxt = (withdraw || accept) ? IDLE : GRANT;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered grant and last_qid.
    always_comb begin
        gnt_vld_nxt  = gnt_vld;
        gnt_qid_nxt  = gnt_qid;
        last_qid_nxt = last_qid;
        case (state)
            IDLE: begin
                gnt_vld_nxt = sel_found;
                if (sel_found) begin
                    gnt_qid_nxt = sel_qid;
                end
            end
            GRANT: begin
                if (withdraw) begin
                    gnt_vld_nxt = 1'b0;
                end else if (accept) begin
                    gnt_vld_nxt  = 1'b0;
                    last_qid_nxt = gnt_qid;
                end
            end
            default: gnt_vld_nxt = 1'b0;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NQ; i++) begin
            q_cnt[i*DESC_CNT_WIDTH +: DESC_CNT_WIDTH] = cnt[i];
            q_rdy[i] = (cnt[i] != '0);
        end
    end

endmodule
